fetch_ras: RTL
==============

FETCH_RAS -- requirements
Module: fetch_ras

Interface
REQ-001 SHALL have parameter DEPTH, default 8, return-address-stack entries (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port nxt_pc  input  16  next-PC from the branch/jump resolution block.
REQ-005 SHALL have port hazard  input  1  stall request from hazard detection.
REQ-006 SHALL have port ex_valid  input  1  ex_instr holds a live instruction this cycle.
REQ-007 SHALL have port ex_pc  input  16  PC of the instruction in EX.
REQ-008 SHALL have port ex_instr  input  16  instruction in EX; opcode is bits [15:12], decoded with the shared opcode header (`CALL, `RET).
REQ-009 SHALL have port imem_rdata  input  16  combinational instruction-memory read data for imem_addr.
REQ-010 SHALL have port if_pc  output  16  current fetch PC, fed back to the next-PC block.
REQ-011 SHALL have port imem_addr  output  16  instruction-memory address, equal to if_pc.
REQ-012 SHALL have port id_pc  output  16  PC of the instruction latched into IF/ID.
REQ-013 SHALL have port id_instr  output  16  instruction latched into IF/ID.
REQ-014 SHALL have port id_valid  output  1  IF/ID holds a fetched instruction.
REQ-015 SHALL have port ras_overflow  output  1  sticky flag: push while the stack was full.
REQ-016 SHALL have port ras_underflow  output  1  sticky flag: pop while the stack was empty.

Function
REQ-017 SHALL register if_pc; imem_addr SHALL be driven from if_pc with no added latency.
REQ-018 SHALL decode push as ex_valid and ex_instr[15:12]==`CALL, and pop as ex_valid and ex_instr[15:12]==`RET; push and pop are mutually exclusive.
REQ-019 On push, SHALL write ex_pc+2 (16-bit wrap) to the top of the stack, so the return lands after the delay slot.
REQ-020 On pop with count>0, SHALL load if_pc with the top entry at the next edge and decrement count; this SHALL override both hazard and nxt_pc.
REQ-021 On pop with count==0, SHALL load if_pc with if_pc+1 and leave count at 0.
REQ-022 Otherwise, SHALL hold if_pc when hazard=1, and load if_pc with nxt_pc when hazard=0.
REQ-023 On push with count==DEPTH, SHALL overwrite the oldest entry (circular), keep count at DEPTH, and lose the oldest address.
REQ-024 Each push/pop SHALL act exactly once per cycle in which ex_valid=1; upstream SHALL drop ex_valid during EX bubbles.
REQ-025 IF/ID SHALL hold id_pc, id_instr and id_valid when hazard=1 and no pop occurs.
REQ-026 Otherwise, IF/ID SHALL load id_pc<=if_pc, id_instr<=imem_rdata and id_valid<=1.
REQ-027 count SHALL range 0..DEPTH; the stack pointer SHALL wrap modulo DEPTH.
REQ-028 All outputs SHALL be glitch-free registers except imem_addr.

Reset
REQ-029 rst_n=0 SHALL immediately force if_pc=0x0000, id_pc=0x0000, id_instr=0x0000, id_valid=0, count=0, pointer=0, ras_overflow=0 and ras_underflow=0.
REQ-030 Reset SHALL NOT clear stack contents; empty is defined only by count.
REQ-031 Reset asserted mid-operation SHALL abandon any push/pop in progress that cycle; the first edge after deassertion SHALL behave as a normal cycle from PC 0x0000.

Configuration
REQ-032 Macro FETCH_RAS_STATUS_EN defined: ras_overflow SHALL set on REQ-023 and ras_underflow on REQ-021, and each SHALL stay set until reset.
REQ-033 Macro FETCH_RAS_STATUS_EN undefined: both flag ports SHALL remain and SHALL be tied to 0, with no flag registers.

Verification
REQ-034 Reset, then hazard=0 with nxt_pc=if_pc+1 for 4 cycles -> if_pc steps 0,1,2,3 and id_pc lags if_pc by one cycle with id_valid=1.
REQ-035 With if_pc=0x0010, set hazard=1 for 3 cycles -> if_pc, id_pc and id_instr are frozen, then resume on release.
REQ-036 CALL at ex_pc=0x0020, then RET with ex_valid -> if_pc=0x0022 one edge after the RET, even with hazard=1 and nxt_pc=0x1234.
REQ-037 DEPTH=8, 9 CALLs at ex_pc 0x100,0x110,...,0x180 -> ras_overflow=1 (macro on); 8 RETs return 0x182 down to 0x112; a 9th RET sets ras_underflow and gives if_pc+1.
REQ-038 RET held in EX for 2 cycles with ex_valid=1 then 0 -> exactly one pop.
REQ-039 rst_n pulsed low mid-cycle with count=3 -> outputs clear asynchronously, count=0, and a subsequent RET underflows.

Source files
------------

// File: rtl/fetch_ras.sv
// fetch_ras: registered fetch PC and IF/ID latch, with a circular
// return-address stack. A CALL in EX pushes its return address and a RET in EX
// redirects fetch to that address.
// Optional build macro FETCH_RAS_STATUS_EN adds sticky ras_overflow and
// ras_underflow flags. When it is undefined, both flag ports are tied to 0.

`ifndef CALL
`define CALL 4'hC
`endif
`ifndef RET
`define RET 4'hD
`endif

module fetch_ras #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] nxt_pc,
  input  logic        hazard,
  input  logic        ex_valid,
  input  logic [15:0] ex_pc,
  input  logic [15:0] ex_instr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] if_pc,
  output logic [15:0] imem_addr,
  output logic [15:0] id_pc,
  output logic [15:0] id_instr,
  output logic        id_valid,
  output logic        ras_overflow,
  output logic        ras_underflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [15:0]   stack [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_top;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [15:0]   ret_addr;
  logic [15:0]   pc_next;
  logic          unused_bits;

  // Decode CALL/RET from the EX opcode. The opcodes differ, so push and pop cannot both be set.
  assign push     = ex_valid && (ex_instr[15:12] == `CALL);
  assign pop      = ex_valid && (ex_instr[15:12] == `RET);
  assign ptr_top  = ptr - PW'(1);
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign ret_addr = 16'(ex_pc + 16'd2);
  assign unused_bits = ^ex_instr[11:0];

  assign imem_addr = if_pc;

  // Select the next fetch PC: a pop wins over hazard and nxt_pc.
  always_comb begin
    pc_next = if_pc;
    if (pop) begin
      if (empty) pc_next = 16'(if_pc + 16'd1);
      else       pc_next = stack[ptr_top];
    end else if (!hazard) begin
      pc_next = nxt_pc;
    end
  end

  // Fetch PC and IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_pc    <= 16'h0000;
      id_pc    <= 16'h0000;
      id_instr <= 16'h0000;
      id_valid <= 1'b0;
    end else begin
      if_pc <= pc_next;
      if (!hazard || pop) begin
        id_pc    <= if_pc;
        id_instr <= imem_rdata;
        id_valid <= 1'b1;
      end
    end
  end

  // Stack pointer and occupancy. A push when full overwrites the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr_top;
      count <= count - CW'(1);
    end
  end

  // Stack storage. Reset does not clear it; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) stack[ptr] <= ret_addr;
  end

`ifdef FETCH_RAS_STATUS_EN
  // Sticky status flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      if (push && full)  ras_overflow  <= 1'b1;
      if (pop && empty)  ras_underflow <= 1'b1;
    end
  end
`else
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

endmodule
